// File: rtl/timer_arbiter_pkg.sv
// Shared types for the timer arbiter: FSM state encoding and index helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index that follows idx in a ring of n entries.
    function automatic int ring_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot winner = first set req at or after the pointer.
// Latency: winner is combinational; pointer moves one clock after advance.
// Backpressure: none; pointer only moves when the caller strobes advance.
module rr_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    input  logic [$clog2(N)-1:0] adv_idx,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] winner_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] pointer;

    // Scan the ring starting at the pointer; the first set request wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(pointer) + k) % N]) begin
                any        = 1'b1;
                winner_idx = IW'((int'(pointer) + k) % N);
                winner[(int'(pointer) + k) % N] = 1'b1;
            end
        end
    end

    // The granted requester drops to lowest priority for the next round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer <= '0;
        end else if (advance) begin
            pointer <= IW'(ring_next(int'(adv_idx), N));
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counting delay timer among NUM_REQ requesters, round-robin.
// Latency: grant 1 clk after req in IDLE; done 1 clk after the expiring tick.
// Backpressure: requesters hold req until done; dropping req aborts silently.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_count,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [WIDTH-1:0]           count
);

    localparam int IW = $clog2(NUM_REQ);

    state_t             state;
    state_t             next_state;
    logic [IW-1:0]      owner;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IW-1:0]      win_idx;
    logic               win_any;
    logic [WIDTH-1:0]   load_val;
    logic               abort;
    logic               expire;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .advance    (state == LOAD),
        .adv_idx    (owner),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    assign load_val = req_count[int'(owner)*WIDTH +: WIDTH];
    // Abort takes precedence over a coincident expiry.
    assign abort    = (state == RUN) && !req[owner];
    assign expire   = (state == RUN) && tick && (count == '0);
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; tick only matters while RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_any) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN: begin
                if (abort)       next_state = IDLE;
                else if (expire) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the winner in IDLE so later req changes cannot move ownership;
    // grant and done are registered so they line up with the FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= '0;
            grant <= '0;
            done  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        owner <= win_idx;
                        grant <= win_onehot;
                    end
                end
                RUN: begin
                    if (abort)       grant <= '0;
                    else if (expire) done  <= grant;
                end
                DONE:    grant <= '0;
                default: ;
            endcase
        end
    end

    // Timer: load once, then decrement on tick, saturating at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (state == LOAD) begin
            count <= load_val;
        end else if (state == RUN && !abort && tick && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: vector table plus multi-cycle sequences.
module tb_timer_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [3:0]  req;
    logic [31:0] req_count;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  count;

    int n_vec = 0;
    int n_err = 0;

    timer_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .req       (req),
        .req_count (req_count),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        tk;
        logic [3:0]  rq;
        logic [31:0] rc;
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
        logic [7:0]  c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic t, input logic [3:0] q,
                                input logic [31:0] rc, input logic [3:0] g,
                                input logic [3:0] d, input logic b, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.tk = t; v.rq = q; v.rc = rc;
        v.g = g; v.d = d; v.b = b; v.c = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [3:0] g, input logic [3:0] d,
                       input logic b, input logic [7:0] c);
        n_vec++;
        if (grant !== g || done !== d || busy !== b || count !== c) begin
            n_err++;
            $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d, want grant=%b done=%b busy=%b count=%0d",
                     nm, grant, done, busy, count, g, d, b, c);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; tick = 1'b0; req_count = '0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        logic [3:0] gs [4];
        gs[0] = 4'b0001; gs[1] = 4'b0010; gs[2] = 4'b0100; gs[3] = 4'b1000;

        // Single requester 1, load 3, tick every cycle: done after 4 RUN ticks.
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0300, 4'b0010, 4'b0000, 1, 8'd0));
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0300, 4'b0010, 4'b0000, 1, 8'd3));
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0300, 4'b0010, 4'b0000, 1, 8'd2));
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0300, 4'b0010, 4'b0000, 1, 8'd1));
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0300, 4'b0010, 4'b0000, 1, 8'd0));
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0300, 4'b0010, 4'b0010, 1, 8'd0));
        tbl.push_back(mk(1, 1, 4'b0000, 32'h0000_0300, 4'b0000, 4'b0000, 0, 8'd0));
        // Reset restores the round-robin pointer to requester 0.
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 0, 8'd0));
        // All four requesting with zero loads: grants rotate 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, 1, 4'b1111, 32'h0, gs[i], 4'b0000, 1, 8'd0));
            tbl.push_back(mk(1, 1, 4'b1111, 32'h0, gs[i], 4'b0000, 1, 8'd0));
            tbl.push_back(mk(1, 1, 4'b1111, 32'h0, gs[i], gs[i],   1, 8'd0));
            tbl.push_back(mk(1, 1, 4'b1111, 32'h0, 4'b0000, 4'b0000, 0, 8'd0));
        end
        tbl.push_back(mk(1, 1, 4'b1111, 32'h0, 4'b0001, 4'b0000, 1, 8'd0));

        reset = 1'b0; tick = 1'b0; req = '0; req_count = '0;
        #1;
        chk("reset_state", 4'b0000, 4'b0000, 1'b0, 8'd0);
        step();
        reset = 1'b1;

        foreach (tbl[i]) begin
            reset     = tbl[i].rst;
            tick      = tbl[i].tk;
            req       = tbl[i].rq;
            req_count = tbl[i].rc;
            step();
            chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].d, tbl[i].b, tbl[i].c);
        end

        // Asynchronous reset in the middle of RUN with count=5.
        do_reset();
        req = 4'b0001; req_count = 32'h0000_0005; tick = 1'b0;
        step();
        step();
        chk("pre_reset_run", 4'b0001, 4'b0000, 1'b1, 8'd5);
        reset = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
        step();
        reset = 1'b1;

        // Abort: requester 2 drops req in RUN with count=7.
        do_reset();
        req = 4'b0100; req_count = 32'h0007_0000; tick = 1'b0;
        step();
        chk("abort_load", 4'b0100, 4'b0000, 1'b1, 8'd0);
        step();
        chk("abort_run", 4'b0100, 4'b0000, 1'b1, 8'd7);
        req = 4'b0000; tick = 1'b1;
        step();
        chk("abort_idle", 4'b0000, 4'b0000, 1'b0, 8'd7);
        step();
        chk("abort_nodone", 4'b0000, 4'b0000, 1'b0, 8'd7);

        // Load 0, ten idle-tick cycles, then one tick expires it.
        do_reset();
        req = 4'b0001; req_count = 32'h0; tick = 1'b0;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("zero_wait%0d", i), 4'b0001, 4'b0000, 1'b1, 8'd0);
        end
        tick = 1'b1;
        step();
        chk("zero_done", 4'b0001, 4'b0001, 1'b1, 8'd0);
        tick = 1'b0; req = 4'b0000;
        step();
        chk("zero_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // req[0] drops on the same cycle as the expiring tick: abort wins.
        do_reset();
        req = 4'b0001; req_count = 32'h0000_0001; tick = 1'b1;
        step();
        step();
        chk("race_run", 4'b0001, 4'b0000, 1'b1, 8'd1);
        step();
        chk("race_zero", 4'b0001, 4'b0000, 1'b1, 8'd0);
        req = 4'b0000;
        step();
        chk("race_abort", 4'b0000, 4'b0000, 1'b0, 8'd0);
        step();
        chk("race_nodone", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // Full-scale load 255 takes 256 ticks; a non-owner req must not intrude.
        do_reset();
        req = 4'b0001; req_count = 32'h0000_00FF; tick = 1'b1;
        step();
        step();
        chk("max_load", 4'b0001, 4'b0000, 1'b1, 8'd255);
        req = 4'b0101;
        for (int i = 0; i < 255; i++) step();
        chk("max_zero", 4'b0001, 4'b0000, 1'b1, 8'd0);
        step();
        chk("max_done", 4'b0001, 4'b0001, 1'b1, 8'd0);
        step();
        chk("max_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
        step();
        chk("max_next_grant", 4'b0100, 4'b0000, 1'b1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
